// File: rtl/breakout_game_seq.sv
// Game-flow sequencer for the Breakout 8x8 LED game: state machine, lives,
// BCD score, step/load strobes for the ball/board engine and game-over wipe.
module breakout_game_seq (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       restart,
  input  logic       pause,
  input  logic [1:0] level,
  input  logic       ball_tick,
  input  logic       ball_drop,
  input  logic       block_hit,
  input  logic       blocks_empty,
  output logic [2:0] state,
  output logic       step_en,
  output logic       serve_load,
  output logic       field_load,
  output logic [1:0] field_sel,
  output logic [1:0] lives,
  output logic [2:0] life_led,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic [2:0] over_anim
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_DROP   = 3'd4,
    S_OVER   = 3'd5,
    S_CLEAR  = 3'd6
  } state_t;

  // Saturating 2-digit BCD increment, result packed as {tens, ones}.
  function automatic logic [7:0] score_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] res;
    if ((tens == 4'd9) && (ones == 4'd9)) begin
      res = {tens, ones};
    end else if (ones == 4'd9) begin
      res = {tens + 4'd1, 4'd0};
    end else begin
      res = {tens, ones + 4'd1};
    end
    return res;
  endfunction

  function automatic logic [2:0] led_of(input logic [1:0] n);
    logic [2:0] res;
    case (n)
      2'd3:    res = 3'b111;
      2'd2:    res = 3'b011;
      2'd1:    res = 3'b001;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  state_t     r_state, w_state;
  logic [1:0] r_lives, w_lives;
  logic [2:0] r_life_led;
  logic [3:0] r_ones, w_ones;
  logic [3:0] r_tens, w_tens;
  logic [2:0] r_anim, w_anim;
  logic [1:0] r_sel, w_sel;
  logic       r_step, w_step;
  logic       r_serve, w_serve;
  logic       r_field, w_field;
  logic       r_start_q, r_restart_q;
  logic       w_start_edge, w_restart_edge;

  // Edge registers reset to 1 so a button held through reset gives no edge.
  assign w_start_edge   = start & ~r_start_q;
  assign w_restart_edge = restart & ~r_restart_q;

  // Next-state, counters and strobes.
  always_comb begin
    w_state = r_state;
    w_lives = r_lives;
    w_ones  = r_ones;
    w_tens  = r_tens;
    w_anim  = r_anim;
    w_sel   = r_sel;
    w_step  = 1'b0;
    w_serve = 1'b0;
    w_field = 1'b0;
    if (w_restart_edge) begin
      w_state = S_IDLE;
      w_lives = 2'd3;
      w_ones  = 4'd0;
      w_tens  = 4'd0;
      w_anim  = 3'd0;
    end else begin
      case (r_state)
        S_IDLE, S_CLEAR: begin
          if (w_start_edge) begin
            w_sel   = level;
            w_field = 1'b1;
            w_serve = 1'b1;
            w_state = S_SERVE;
          end else begin
            w_state = r_state;
          end
        end
        S_SERVE: begin
          if (ball_tick) w_state = S_PLAY;
          else           w_state = r_state;
        end
        S_PLAY: begin
          if (block_hit) {w_tens, w_ones} = score_inc(r_tens, r_ones);
          else           {w_tens, w_ones} = {r_tens, r_ones};
          // step_en is only raised when staying in PLAY, so leaving suppresses it.
          if (blocks_empty) begin
            w_state = S_CLEAR;
          end else if (ball_drop) begin
            if (r_lives <= 2'd1) begin
              w_lives = 2'd0;
              w_state = S_OVER;
            end else begin
              w_lives = r_lives - 2'd1;
              w_state = S_DROP;
            end
          end else if (pause) begin
            w_state = S_PAUSED;
          end else if (ball_tick) begin
            w_step = 1'b1;
          end else begin
            w_step = 1'b0;
          end
        end
        S_PAUSED: begin
          if (!pause) w_state = S_PLAY;
          else        w_state = r_state;
        end
        S_DROP: begin
          if (w_start_edge) begin
            w_serve = 1'b1;
            w_state = S_SERVE;
          end else begin
            w_state = r_state;
          end
        end
        S_OVER: begin
          if (ball_tick && (r_anim != 3'd7)) w_anim = r_anim + 3'd1;
          else                               w_anim = r_anim;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_lives     <= 2'd3;
      r_life_led  <= 3'b111;
      r_ones      <= 4'd0;
      r_tens      <= 4'd0;
      r_anim      <= 3'd0;
      r_sel       <= 2'd0;
      r_step      <= 1'b0;
      r_serve     <= 1'b0;
      r_field     <= 1'b0;
      r_start_q   <= 1'b1;
      r_restart_q <= 1'b1;
    end else begin
      r_state     <= w_state;
      r_lives     <= w_lives;
      r_life_led  <= led_of(w_lives);
      r_ones      <= w_ones;
      r_tens      <= w_tens;
      r_anim      <= w_anim;
      r_sel       <= w_sel;
      r_step      <= w_step;
      r_serve     <= w_serve;
      r_field     <= w_field;
      r_start_q   <= start;
      r_restart_q <= restart;
    end
  end

  assign state      = r_state;
  assign step_en    = r_step;
  assign serve_load = r_serve;
  assign field_load = r_field;
  assign field_sel  = r_sel;
  assign lives      = r_lives;
  assign life_led   = r_life_led;
  assign score_ones = r_ones;
  assign score_tens = r_tens;
  assign over_anim  = r_anim;

endmodule
